time_display_scan: RTL and testbench

//  Downstream of the CLOCK time-keeping counter.

---
 rtl/clock_pkg.sv | 41 ++++
 rtl/time_display_scan_seg7_decode.sv | 37 +++
 rtl/time_display_scan.sv | 182 ++++++++++++++++++
 tb/tb_time_display_scan.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : clock_pkg
//  Description : Shared constants, types and helpers for the clock display
//                path: digit indices, active-low segment patterns, special
//                BCD codes and the binary-to-two-digit BCD split.
//  Revision    : 1.0 - initial release
// ============================================================================
package clock_pkg;

    localparam int NUM_DIGITS = 6;

    // Active-low segment patterns, bit0 = segment a
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;  // only segment g lit

    // Non-decimal codes carried on the 4-bit digit path
    localparam logic [3:0] BCD_DASH  = 4'hA;
    localparam logic [3:0] BCD_BLANK = 4'hB;

    typedef logic [2:0] digit_idx_t;

    // Digit positions, 0 is the rightmost digit
    localparam digit_idx_t DIG_SEC_ONES = 3'd0;
    localparam digit_idx_t DIG_SEC_TENS = 3'd1;
    localparam digit_idx_t DIG_MIN_ONES = 3'd2;
    localparam digit_idx_t DIG_MIN_TENS = 3'd3;
    localparam digit_idx_t DIG_HR_ONES  = 3'd4;
    localparam digit_idx_t DIG_HR_TENS  = 3'd5;

    // Returns {tens, ones}; values above 99 cannot be shown in two digits,
    // so both positions become a dash.
    function automatic logic [7:0] bcd_split(input logic [6:0] value);
        if (value > 7'd99) begin
            return {BCD_DASH, BCD_DASH};
        end
        return {4'(value / 7'd10), 4'(value % 7'd10)};
    endfunction

endpackage : clock_pkg
`default_nettype wire

// File: rtl/time_display_scan_seg7_decode.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_decode
//  Description : Combinational 4-bit digit code to active-low 7-segment
//                pattern. Codes 0-9 are decimal digits, BCD_DASH lights only
//                segment g, every other code is blank.
//  Ports       : code   in  4  digit code
//                seg_n  out 7  segments a..g (bit0 = a), active-low
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_decode
    import clock_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] seg_n
);

    always_comb begin
        seg_n = SEG_BLANK;
        case (code)
            4'd0:     seg_n = 7'h40;
            4'd1:     seg_n = 7'h79;
            4'd2:     seg_n = 7'h24;
            4'd3:     seg_n = 7'h30;
            4'd4:     seg_n = 7'h19;
            4'd5:     seg_n = 7'h12;
            4'd6:     seg_n = 7'h02;
            4'd7:     seg_n = 7'h78;
            4'd8:     seg_n = 7'h00;
            4'd9:     seg_n = 7'h10;
            BCD_DASH: seg_n = SEG_DASH;
            default:  seg_n = SEG_BLANK;
        endcase
    end

endmodule : seg7_decode
`default_nettype wire

// File: rtl/time_display_scan.sv
`default_nettype none
// ============================================================================
//  Module      : time_display_scan
//  Description : Multiplexed 6-digit common-anode 7-segment driver for
//                HH.MM.SS. Snapshots the time once per scan frame, splits
//                each field into two BCD digits, scans one digit per tick and
//                blinks the separators with seconds bit 0.
//  Ports       : clk          in   1  system clock
//                reset        in   1  synchronous reset, active-low
//                enable       in   1  1 = display active, 0 = dark and frozen
//                sec_count    in   7  seconds, binary
//                min_count    in   7  minutes, binary
//                hour_count   in   5  hours, binary
//                seg_n        out  7  segments a..g, active-low, registered
//                dp_n         out  1  separator point, active-low, registered
//                an_n         out  6  one-hot active-low anodes, registered
//                frame_start  out  1  pulse when digit 0 selected + snapshot
//  Revision    : 1.0 - initial release
// ============================================================================
module time_display_scan
    import clock_pkg::*;
#(
    parameter int CLK_HZ        = 50000000,
    parameter int SCAN_HZ       = 6000,
    parameter int HOUR_LZ_BLANK = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [6:0]            sec_count,
    input  logic [6:0]            min_count,
    input  logic [4:0]            hour_count,
    output logic [6:0]            seg_n,
    output logic                  dp_n,
    output logic [NUM_DIGITS-1:0] an_n,
    output logic                  frame_start
);

    localparam int c_scan_div = CLK_HZ / SCAN_HZ;
    localparam int c_cnt_w    = (c_scan_div > 2) ? $clog2(c_scan_div) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(c_scan_div - 1);

    logic [c_cnt_w-1:0]    r_scan_cnt;
    digit_idx_t            r_digit_idx;
    logic                  r_first;      // no tick seen since reset release
    logic [6:0]            r_snap_sec;
    logic [6:0]            r_snap_min;
    logic [4:0]            r_snap_hour;
    logic                  r_frame_start;
    logic [6:0]            r_seg_n;
    logic                  r_dp_n;
    logic [NUM_DIGITS-1:0] r_an_n;

    logic                  w_tick;
    digit_idx_t            w_next_idx;
    logic                  w_wrap;
    logic [7:0]            w_sec_bcd;
    logic [7:0]            w_min_bcd;
    logic [7:0]            w_hr_bcd;
    logic [3:0]            w_code;
    logic [NUM_DIGITS-1:0] w_an_n;
    logic                  w_dp_n;
    logic [6:0]            w_seg_n;

    // ---------------- prescaler and digit counter -------------------------
    assign w_tick = enable && (r_scan_cnt == c_cnt_max);

    // The first tick after reset behaves as a wrap so the frame starts
    // cleanly at digit 0 with a fresh snapshot.
    always_comb begin
        w_next_idx = DIG_SEC_ONES;
        if (!r_first && (r_digit_idx != DIG_HR_TENS)) begin
            w_next_idx = r_digit_idx + 3'd1;
        end
    end

    assign w_wrap = w_tick && (w_next_idx == DIG_SEC_ONES);

    // ---------------- BCD split of the snapshot ---------------------------
    assign w_sec_bcd = bcd_split(r_snap_sec);
    assign w_min_bcd = bcd_split(r_snap_min);
    assign w_hr_bcd  = bcd_split({2'b00, r_snap_hour});

    // ---------------- digit mux -------------------------------------------
    // Separators sit after the minutes-ones and hours-ones digits and are lit
    // on even seconds, giving a 1 Hz blink.
    always_comb begin
        w_code = BCD_BLANK;
        w_an_n = '1;
        w_dp_n = 1'b1;
        case (r_digit_idx)
            DIG_SEC_ONES: begin
                w_code = w_sec_bcd[3:0];
                w_an_n = 6'b111110;
            end
            DIG_SEC_TENS: begin
                w_code = w_sec_bcd[7:4];
                w_an_n = 6'b111101;
            end
            DIG_MIN_ONES: begin
                w_code = w_min_bcd[3:0];
                w_an_n = 6'b111011;
                w_dp_n = r_snap_sec[0];
            end
            DIG_MIN_TENS: begin
                w_code = w_min_bcd[7:4];
                w_an_n = 6'b110111;
            end
            DIG_HR_ONES: begin
                w_code = w_hr_bcd[3:0];
                w_an_n = 6'b101111;
                w_dp_n = r_snap_sec[0];
            end
            DIG_HR_TENS: begin
                w_code = ((HOUR_LZ_BLANK != 0) && (w_hr_bcd[7:4] == 4'd0))
                         ? BCD_BLANK : w_hr_bcd[7:4];
                w_an_n = 6'b011111;
            end
            default: begin
                w_code = BCD_BLANK;
                w_an_n = '1;
            end
        endcase
    end

    seg7_decode u_seg7_decode (
        .code  (w_code),
        .seg_n (w_seg_n)
    );

    // ---------------- registers -------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_scan_cnt    <= '0;
            r_digit_idx   <= DIG_SEC_ONES;
            r_first       <= 1'b1;
            r_snap_sec    <= '0;
            r_snap_min    <= '0;
            r_snap_hour   <= '0;
            r_frame_start <= 1'b0;
            r_seg_n       <= SEG_BLANK;
            r_dp_n        <= 1'b1;
            r_an_n        <= '1;
        end else begin
            r_frame_start <= w_wrap;

            if (enable) begin
                r_scan_cnt <= w_tick ? '0 : r_scan_cnt + 1'b1;
            end

            if (w_tick) begin
                r_digit_idx <= w_next_idx;
                r_first     <= 1'b0;
            end

            if (w_wrap) begin
                r_snap_sec  <= sec_count;
                r_snap_min  <= min_count;
                r_snap_hour <= hour_count;
            end

            // Anode, segments and point are registered together; keep the
            // display dark until the first digit has actually been selected.
            if (!enable || r_first) begin
                r_seg_n <= SEG_BLANK;
                r_dp_n  <= 1'b1;
                r_an_n  <= '1;
            end else begin
                r_seg_n <= w_seg_n;
                r_dp_n  <= w_dp_n;
                r_an_n  <= w_an_n;
            end
        end
    end

    assign seg_n       = r_seg_n;
    assign dp_n        = r_dp_n;
    assign an_n        = r_an_n;
    assign frame_start = r_frame_start;

endmodule : time_display_scan
`default_nettype wire

// File: tb/tb_time_display_scan.sv
`default_nettype none
// ============================================================================
//  Module      : tb_time_display_scan
//  Description : Directed self-checking bench for time_display_scan with
//                CLK_HZ=12, SCAN_HZ=6 (two clocks per digit, 12 per frame).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_time_display_scan;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b1;
    logic [6:0] sec_count = 7'd58;
    logic [6:0] min_count = 7'd59;
    logic [4:0] hour_count = 5'd11;
    logic [6:0] seg_n;
    logic       dp_n;
    logic [5:0] an_n;
    logic       frame_start;

    int n_chk = 0;
    int n_err = 0;

    logic [6:0] cap_seg [6];
    logic [5:0] cap_an  [6];
    logic       cap_dp  [6];

    time_display_scan #(
        .CLK_HZ        (12),
        .SCAN_HZ       (6),
        .HOUR_LZ_BLANK (1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .sec_count   (sec_count),
        .min_count   (min_count),
        .hour_count  (hour_count),
        .seg_n       (seg_n),
        .dp_n        (dp_n),
        .an_n        (an_n),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advances at least one cycle, then until frame_start is seen (bounded).
    task automatic wait_fs(input string tag);
        int k;
        k = 0;
        do begin
            step();
            k++;
        end while (frame_start !== 1'b1 && k < 40);
        chk(tag, 32'(frame_start), 1);
    endtask

    // Called at the frame_start sample point; digit k is on the outputs
    // 1+2k cycles later. Ends at the next frame_start sample point.
    task automatic capture();
        for (int k = 0; k < 6; k++) begin
            step();
            cap_seg[k] = seg_n;
            cap_an[k]  = an_n;
            cap_dp[k]  = dp_n;
            step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---- 1: reset values and first tick ----
        step(); step(); step();
        chk("rst_seg", 32'(seg_n), 'h7F);
        chk("rst_an", 32'(an_n), 'h3F);
        chk("rst_dp", 32'(dp_n), 1);
        chk("rst_fs", 32'(frame_start), 0);
        reset = 1'b1;
        step();
        chk("pre_tick_fs", 32'(frame_start), 0);
        chk("pre_tick_an", 32'(an_n), 'h3F);
        step();
        chk("first_tick_fs", 32'(frame_start), 1);

        // ---- 2: 11:59:58 ----
        capture();
        chk("t2_an0", 32'(cap_an[0]), 'h3E);
        chk("t2_an5", 32'(cap_an[5]), 'h1F);
        chk("t2_an3", 32'(cap_an[3]), 'h37);
        chk("t2_d0", 32'(cap_seg[0]), 'h00);
        chk("t2_d1", 32'(cap_seg[1]), 'h12);
        chk("t2_d2", 32'(cap_seg[2]), 'h10);
        chk("t2_d3", 32'(cap_seg[3]), 'h12);
        chk("t2_d4", 32'(cap_seg[4]), 'h79);
        chk("t2_d5", 32'(cap_seg[5]), 'h79);
        chk("t2_dp0", 32'(cap_dp[0]), 1);
        chk("t2_dp2", 32'(cap_dp[2]), 0);
        chk("t2_dp4", 32'(cap_dp[4]), 0);

        // ---- 3: 03:07:09, leading zero blank, odd second ----
        hour_count = 5'd3; min_count = 7'd7; sec_count = 7'd9;
        wait_fs("t3_fs");
        capture();
        chk("t3_d0", 32'(cap_seg[0]), 'h10);
        chk("t3_d1", 32'(cap_seg[1]), 'h40);
        chk("t3_d2", 32'(cap_seg[2]), 'h78);
        chk("t3_d4", 32'(cap_seg[4]), 'h30);
        chk("t3_d5_blank", 32'(cap_seg[5]), 'h7F);
        chk("t3_an5", 32'(cap_an[5]), 'h1F);
        chk("t3_dp2", 32'(cap_dp[2]), 1);
        chk("t3_dp4", 32'(cap_dp[4]), 1);

        // ---- 4: mid-frame change 58 -> 59 ----
        hour_count = 5'd11; min_count = 7'd59; sec_count = 7'd58;
        wait_fs("t4_fs0");
        for (int k = 0; k < 5; k++) step();
        chk("t4_an_d2", 32'(an_n), 'h3B);
        sec_count = 7'd59;
        for (int k = 0; k < 4; k++) step();
        chk("t4_an_d4", 32'(an_n), 'h2F);
        chk("t4_dp4_old", 32'(dp_n), 0);
        wait_fs("t4_fs1");
        capture();
        chk("t4_d0_new", 32'(cap_seg[0]), 'h10);
        chk("t4_d1_new", 32'(cap_seg[1]), 'h12);
        chk("t4_dp2_new", 32'(cap_dp[2]), 1);

        // ---- 5: sec=100 dash, then enable freeze ----
        sec_count = 7'd100;
        wait_fs("t5_fs");
        capture();
        chk("t5_d0_dash", 32'(cap_seg[0]), 'h3F);
        chk("t5_d1_dash", 32'(cap_seg[1]), 'h3F);
        chk("t5_d2", 32'(cap_seg[2]), 'h10);
        chk("t5_dp2", 32'(cap_dp[2]), 0);
        for (int k = 0; k < 5; k++) step();
        chk("t5_an_d2", 32'(an_n), 'h3B);
        enable = 1'b0;
        step();
        chk("t5_dis_an", 32'(an_n), 'h3F);
        chk("t5_dis_seg", 32'(seg_n), 'h7F);
        chk("t5_dis_dp", 32'(dp_n), 1);
        for (int k = 0; k < 4; k++) step();
        chk("t5_dis_an_hold", 32'(an_n), 'h3F);
        chk("t5_dis_fs", 32'(frame_start), 0);
        enable = 1'b1;
        step();
        chk("t5_resume_an", 32'(an_n), 'h3B);
        step();
        chk("t5_next_an", 32'(an_n), 'h37);

        // ---- 6: reset during digit 3 ----
        reset = 1'b0;
        step();
        chk("t6_rst_an", 32'(an_n), 'h3F);
        chk("t6_rst_seg", 32'(seg_n), 'h7F);
        chk("t6_rst_dp", 32'(dp_n), 1);
        chk("t6_rst_fs", 32'(frame_start), 0);
        hour_count = 5'd22; min_count = 7'd45; sec_count = 7'd30;
        step();
        reset = 1'b1;
        step();
        chk("t6_pre_fs", 32'(frame_start), 0);
        chk("t6_pre_an", 32'(an_n), 'h3F);
        step();
        chk("t6_fs", 32'(frame_start), 1);
        capture();
        chk("t6_an0", 32'(cap_an[0]), 'h3E);
        chk("t6_d0", 32'(cap_seg[0]), 'h40);
        chk("t6_d1", 32'(cap_seg[1]), 'h30);
        chk("t6_d2", 32'(cap_seg[2]), 'h12);
        chk("t6_d3", 32'(cap_seg[3]), 'h19);
        chk("t6_d4", 32'(cap_seg[4]), 'h24);
        chk("t6_d5", 32'(cap_seg[5]), 'h24);
        chk("t6_dp2", 32'(cap_dp[2]), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule : tb_time_display_scan
`default_nettype wire
